// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller:
// fill FSM state encoding, geometry defaults and the address-field widths they imply.
package icache_ctrl_pkg;

  localparam int LINES_DEF   = 16;
  localparam int WORDS_DEF   = 4;
  localparam int INDEX_W_DEF = $clog2(LINES_DEF);
  localparam int WORD_W_DEF  = $clog2(WORDS_DEF);
  localparam int TAG_W_DEF   = 32 - INDEX_W_DEF - WORD_W_DEF - 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one write port
// (beat write, valid set/clear, invalidate-all) and a combinational read port.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int IDX_W = INDEX_W_DEF,
  parameter int WRD_W = WORD_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [WRD_W-1:0] rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WRD_W-1:0] wr_word,
  input  logic             wr_data_en,
  input  logic [31:0]      wr_data,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             set_valid,
  input  logic             clr_valid,
  input  logic             inv_all
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS];

  // Invalidate-all wins so an aborted fill can never validate its line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[wr_index] <= 1'b1;
    end else if (clr_valid) begin
      valid_q[wr_index] <= 1'b0;
    end
  end

  // NOTE: tag/data flops are deliberately left out of reset; the valid bit
  // guards every read, so resetting them would only cost reset-tree fanout.
  always_ff @(posedge clk_i) begin
    if (wr_data_en) data_q[{wr_index, wr_word}] <= wr_data;
    if (set_valid)  tag_q[wr_index]             <= wr_tag;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_word}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency hit path and an
// in-order line-fill FSM towards backing memory, with invalidate and miss counting.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        inv_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  output logic [15:0] miss_cnt_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int WRD_W = $clog2(WORDS);
  localparam int TAG_W = 32 - IDX_W - WRD_W - 2;
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS - 1);

  logic [WRD_W-1:0] addr_word;
  logic [IDX_W-1:0] addr_index;
  logic [TAG_W-1:0] addr_tag;
  logic             unused_offset;

  assign addr_word     = addr_i[WRD_W+1:2];
  assign addr_index    = addr_i[IDX_W+WRD_W+1:WRD_W+2];
  assign addr_tag      = addr_i[31:IDX_W+WRD_W+2];
  assign unused_offset = ^addr_i[1:0];

  fill_state_e      state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [WRD_W-1:0] beat_q, beat_d;
  logic [15:0]      miss_q, miss_d;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             wr_data_en, set_valid, clr_valid, inv_all;
  logic [IDX_W-1:0] wr_index;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      beat_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      beat_q  <= beat_d;
      miss_q  <= miss_d;
    end
  end

  assign hit = (state_q == IDLE) && rd_valid && (rd_tag == addr_tag);

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    index_d    = index_q;
    beat_d     = beat_q;
    miss_d     = miss_q;
    wr_data_en = 1'b0;
    set_valid  = 1'b0;
    clr_valid  = 1'b0;
    inv_all    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inv_i) begin
          inv_all = 1'b1;
        end else if (!hit) begin
          state_d   = FILL;
          tag_d     = addr_tag;
          index_d   = addr_index;
          beat_d    = '0;
          miss_d    = miss_q + 16'd1;
          clr_valid = 1'b1;
        end
      end
      FILL: begin
        if (inv_i) begin
          inv_all = 1'b1;
          state_d = IDLE;
        end else if (mem_ready_i) begin
          wr_data_en = 1'b1;
          beat_d     = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            set_valid = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line being cleared on a miss is the looked-up one; during a fill it is the latched one.
  assign wr_index = (state_q == FILL) ? index_q : addr_index;

  icache_array #(
    .LINES(LINES),
    .WORDS(WORDS),
    .IDX_W(IDX_W),
    .WRD_W(WRD_W),
    .TAG_W(TAG_W)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_index  (addr_index),
    .rd_word   (addr_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_index  (wr_index),
    .wr_word   (beat_q),
    .wr_data_en(wr_data_en),
    .wr_data   (mem_data_i),
    .wr_tag    (tag_q),
    .set_valid (set_valid),
    .clr_valid (clr_valid),
    .inv_all   (inv_all)
  );

  assign valid_o    = hit && !inv_i;
  assign data_o     = valid_o ? rd_data : 32'h0;
  assign mem_req_o  = (state_q == FILL);
  assign mem_addr_o = mem_req_o ? {tag_q, index_q, beat_q, 2'b00} : 32'h0;
  assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: cold miss, hits, eviction, backpressure,
// invalidate during fill and idle, and asynchronous reset mid-fill.
module tb_icache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        inv_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic [15:0] miss_cnt_o;

  int total = 0;
  int bad   = 0;

  icache_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .inv_i      (inv_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ready_i(mem_ready_i),
    .mem_data_i (mem_data_i),
    .miss_cnt_o (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Miss on addr with memory always ready; beats carry dbase+beat.
  task automatic fill(input logic [31:0] addr, input logic [31:0] dbase, input logic [15:0] cnt);
    logic [31:0] line;
    line   = {addr[31:4], 4'h0};
    addr_i = addr;
    mem_ready_i = 1'b1;
    #1;
    check("miss_valid", {31'd0, valid_o}, 32'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      check("fill_req", {31'd0, mem_req_o}, 32'd1);
      check("fill_addr", mem_addr_o, line + 32'(4 * b));
      check("fill_valid", {31'd0, valid_o}, 32'd0);
      mem_data_i = dbase + 32'(b);
      tick();
    end
    check("fill_done_req", {31'd0, mem_req_o}, 32'd0);
    check("fill_hit_valid", {31'd0, valid_o}, 32'd1);
    check("fill_hit_data", data_o, dbase + 32'(addr[3:2]));
    check("fill_miss_cnt", {16'd0, miss_cnt_o}, {16'd0, cnt});
  endtask

  initial begin
    rst_i       = 1'b1;
    addr_i      = 32'h40;
    inv_i       = 1'b0;
    mem_ready_i = 1'b1;
    mem_data_i  = 32'h0;
    #12;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_cnt", {16'd0, miss_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Cold miss on 0x40, then same-line hits.
    fill(32'h40, 32'h1000_0000, 16'd1);
    for (int w = 1; w < 4; w++) begin
      tick();
      addr_i = 32'h40 + 32'(4 * w);
      #1;
      check("hit_valid", {31'd0, valid_o}, 32'd1);
      check("hit_data", data_o, 32'h1000_0000 + 32'(w));
      check("hit_req", {31'd0, mem_req_o}, 32'd0);
    end
    check("hit_cnt", {16'd0, miss_cnt_o}, 32'd1);

    // Conflict eviction on index 4.
    tick();
    fill(32'h140, 32'h2000_0000, 16'd2);
    tick();
    fill(32'h40, 32'h3000_0000, 16'd3);

    // Backpressure: three idle cycles before each accepted beat.
    tick();
    addr_i      = 32'h80;
    mem_ready_i = 1'b0;
    #1;
    check("bp_miss_valid", {31'd0, valid_o}, 32'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) begin
        check("bp_hold_addr", mem_addr_o, 32'h80 + 32'(4 * b));
        check("bp_hold_req", {31'd0, mem_req_o}, 32'd1);
        tick();
      end
      mem_ready_i = 1'b1;
      mem_data_i  = 32'h4000_0000 + 32'(b);
      check("bp_beat_addr", mem_addr_o, 32'h80 + 32'(4 * b));
      check("bp_beat_valid", {31'd0, valid_o}, 32'd0);
      tick();
      mem_ready_i = 1'b0;
    end
    check("bp_valid_c17", {31'd0, valid_o}, 32'd1);
    check("bp_data", data_o, 32'h4000_0000);
    check("bp_cnt", {16'd0, miss_cnt_o}, 32'd4);

    // Invalidate at beat 2 aborts the fill; the address then refetches from beat 0.
    tick();
    mem_ready_i = 1'b1;
    addr_i      = 32'hC0;
    tick();
    mem_data_i = 32'h5000_0000;
    tick();
    mem_data_i = 32'h5000_0001;
    tick();
    check("inv_beat2_addr", mem_addr_o, 32'hC8);
    inv_i = 1'b1;
    tick();
    inv_i = 1'b0;
    check("inv_abort_req", {31'd0, mem_req_o}, 32'd0);
    check("inv_abort_valid", {31'd0, valid_o}, 32'd0);
    check("inv_abort_cnt", {16'd0, miss_cnt_o}, 32'd5);
    tick();
    check("refetch_beat0", mem_addr_o, 32'hC0);
    for (int b = 0; b < 4; b++) begin
      mem_data_i = 32'h6000_0000 + 32'(b);
      tick();
    end
    check("refetch_valid", {31'd0, valid_o}, 32'd1);
    check("refetch_data", data_o, 32'h6000_0000);
    check("refetch_cnt", {16'd0, miss_cnt_o}, 32'd6);

    // Invalidate masks a hit in the same cycle, then clears the line.
    inv_i = 1'b1;
    #1;
    check("inv_mask_valid", {31'd0, valid_o}, 32'd0);
    check("inv_mask_data", data_o, 32'd0);
    tick();
    // Invalidate together with a lookup miss: no fill, no count.
    addr_i = 32'h40;
    #1;
    tick();
    inv_i = 1'b0;
    check("inv_miss_req", {31'd0, mem_req_o}, 32'd0);
    check("inv_miss_cnt", {16'd0, miss_cnt_o}, 32'd6);

    // Fill a fresh line, then reset asynchronously in the middle of another fill.
    fill(32'h100, 32'h7000_0000, 16'd7);
    tick();
    addr_i = 32'h150;
    tick();
    mem_data_i = 32'h8000_0000;
    tick();
    check("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_req", {31'd0, mem_req_o}, 32'd0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_cnt", {16'd0, miss_cnt_o}, 32'd0);
    check("arst_addr", mem_addr_o, 32'd0);
    rst_i  = 1'b0;
    addr_i = 32'h104;
    #1;
    check("post_rst_miss", {31'd0, valid_o}, 32'd0);
    tick();
    check("post_rst_req", {31'd0, mem_req_o}, 32'd1);
    check("post_rst_addr", mem_addr_o, 32'h100);
    check("post_rst_cnt", {16'd0, miss_cnt_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
